// File: rtl/mem_access_pkg.sv
// Package: mem_access_pkg
// Access-size encodings, FSM state type and address helper shared by the load/store unit.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StWait = 3'd2,
        StWr   = 3'd3,
        StResp = 3'd4,
        StErr  = 3'd5
    } state_e;

    // Word-aligned form of a byte address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Module: byte_lane_merge
// Little-endian lane handling: load extract with sign/zero extension and
// store merge of a byte/half lane into a full memory word.
module byte_lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_pos;
    logic [4:0]  half_pos;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_pos = {offset_i, 3'b000};
    assign half_pos = {offset_i[1], 4'b0000};
    assign byte_sel = word_i[byte_pos +: 8];
    assign half_sel = word_i[half_pos +: 16];

    // Load result: selected lane, extended to 32 bits
    always_comb begin
        load_o = word_i;
        case (size_i)
            SIZE_BYTE: load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default:   load_o = word_i;
        endcase
    end

    // Store word: replace only the addressed lane; a word store passes data through
    always_comb begin
        merged_o = word_i;
        case (size_i)
            SIZE_BYTE: merged_o[byte_pos +: 8]  = data_i[7:0];
            SIZE_HALF: merged_o[half_pos +: 16] = data_i[15:0];
            SIZE_WORD: merged_o                 = data_i;
            default:   merged_o                 = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Module: mem_access_unit
// Load/store initiator for a word-organised data memory with a one-cycle read.
// Sub-word stores are done as read-modify-write. Optional build macro
// MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses;
// without it the offending low address bits are cleared.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RspValid,
    output logic [31:0] RspData,
    output logic        RspErr,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    // The WAIT state assumes read data arrives exactly one cycle after MemRead.
    if (MEM_RD_LAT != 1) begin : g_rd_lat_check
        $error("mem_access_unit: only MEM_RD_LAT = 1 is supported");
    end

    state_e      state_q, state_d;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        req_fire;
    logic        req_err;
    logic        misalign;
    logic [31:0] req_addr;
    logic [31:0] load_data;
    logic [31:0] merged_data;

    // Misaligned half/word: either flag it or silently align the address
    always_comb begin
        req_addr = ReqAddr;
        misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (ReqSize == SIZE_HALF) begin
            misalign = ReqAddr[0];
        end else if (ReqSize == SIZE_WORD) begin
            misalign = |ReqAddr[1:0];
        end
`else
        if (ReqSize == SIZE_HALF) begin
            req_addr[0] = 1'b0;
        end else if (ReqSize == SIZE_WORD) begin
            req_addr[1:0] = 2'b00;
        end
`endif
    end

    assign req_fire = ReqValid && (state_q == StIdle);
    // Range check uses the address as presented, before any alignment
    assign req_err  = (ReqSize == SIZE_RSVD) || (ReqAddr >= ADDR_LIMIT) || misalign;

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (ReqValid) begin
                    if (req_err) begin
                        state_d = StErr;
                    end else if (ReqWrite && (ReqSize == SIZE_WORD)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = StWait;
            StWait:  state_d = write_q ? StWr : StResp;
            StWr:    state_d = StResp;
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register; reset aborts any in-flight access immediately
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture at accept and read-data capture in WAIT
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            write_q  <= 1'b0;
            size_q   <= SIZE_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
        end else begin
            if (req_fire) begin
                write_q  <= ReqWrite;
                size_q   <= ReqSize;
                signed_q <= ReqSigned;
                addr_q   <= req_addr;
                wdata_q  <= ReqWData;
            end
            if (state_q == StWait) begin
                word_q <= MemReadData;
            end
        end
    end

    byte_lane_merge u_lane (
        .word_i   (word_q),
        .data_i   (wdata_q),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .load_o   (load_data),
        .merged_o (merged_data)
    );

    // Outputs decoded from state; everything idles at zero
    always_comb begin
        ReqReady     = Reset_n && (state_q == StIdle);
        RspValid     = 1'b0;
        RspErr       = 1'b0;
        RspData      = '0;
        MemAddress   = '0;
        MemWriteData = '0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        case (state_q)
            StRd: begin
                MemRead    = 1'b1;
                MemAddress = word_align(addr_q);
            end
            StWr: begin
                MemWrite     = 1'b1;
                MemAddress   = word_align(addr_q);
                MemWriteData = merged_data;
            end
            StResp: begin
                RspValid = 1'b1;
                RspData  = write_q ? 32'h0 : load_data;
            end
            StErr: begin
                RspValid = 1'b1;
                RspErr   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
